alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_if.sv | 45 ++++
 rtl/alu_issue.sv | 136 +++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Issue-block bundle: upstream op handshake, registered ALU drive/return, downstream result handshake.
// No storage; pure wiring shared by the issue block and its environment.
// Backpressure travels on in_valid/in_ready and out_valid/out_ready.
interface alu_issue_if;
  // upstream operation
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic        in_ignore_op2;
  // ALU drive and return
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic        alu_ignore_op2;
  logic [1:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  // downstream result
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_illegal;

  // environment side: supplies ops, models the ALU, consumes results
  modport master (
    output in_valid, in_op, in_op1, in_op2, in_ignore_op2,
    input  in_ready,
    input  alu_op1, alu_op2, alu_ignore_op2, alu_ctrl,
    output alu_result, alu_zero,
    input  out_valid, out_result, out_zero, out_illegal,
    output out_ready
  );

  // issue block side
  modport slave (
    input  in_valid, in_op, in_op1, in_op2, in_ignore_op2,
    output in_ready,
    output alu_op1, alu_op2, alu_ignore_op2, alu_ctrl,
    input  alu_result, alu_zero,
    output out_valid, out_result, out_zero, out_illegal,
    input  out_ready
  );
endinterface

// File: rtl/alu_issue.sv
// ALU issue stage: latches one op, drives a combinational ALU from registers, holds the result for handoff.
// Latency accept->out_valid: illegal 1, add/sub 2, mul 2 (MUL_LATENCY+1 with ALU_MUL_MULTICYCLE_EN defined).
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_issue #(
  parameter int MUL_LATENCY = 4
) (
  input  logic       clk,
  input  logic       reset,
  alu_issue_if.slave bus
);

  // multiply latency must fit the 4-bit wait counter and leave room for one wait cycle
  if (MUL_LATENCY < 2 || MUL_LATENCY > 15) begin : g_bad_mul_latency
    $error("alu_issue: MUL_LATENCY must be in 2..15");
  end

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
`ifdef ALU_MUL_MULTICYCLE_EN
    MUL_WAIT = 2'd2,
`endif
    DONE     = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        ign_q;
  logic [1:0]  ctrl_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        ill_q;

  logic        in_ready_c;
  logic        out_valid_c;
  logic        capture;
  logic        xfer;

`ifdef ALU_MUL_MULTICYCLE_EN
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);
  logic [3:0]  cnt_q;
  logic        is_mul;
  assign is_mul = (ctrl_q == 2'b01);
`endif

  assign xfer = bus.in_valid && in_ready_c;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = (bus.in_op == OP_ILLEGAL) ? DONE : EXEC;
`ifdef ALU_MUL_MULTICYCLE_EN
      EXEC:     state_d = is_mul ? MUL_WAIT : DONE;
      MUL_WAIT: if (cnt_q == 4'd1) state_d = DONE;
`else
      EXEC:     state_d = DONE;
`endif
      DONE: if (bus.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // state-decoded outputs and result capture strobe
  always_comb begin
    in_ready_c  = (state_q == IDLE);
    out_valid_c = (state_q == DONE);
`ifdef ALU_MUL_MULTICYCLE_EN
    capture     = ((state_q == EXEC) && !is_mul) ||
                  ((state_q == MUL_WAIT) && (cnt_q == 4'd1));
`else
    capture     = (state_q == EXEC);
`endif
  end

`ifdef ALU_MUL_MULTICYCLE_EN
  // multiply wait counter: loaded in EXEC, the capture happens when it reaches 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt_q <= 4'd0;
    else if ((state_q == EXEC) && is_mul) cnt_q <= MUL_LOAD;
    else if (state_q == MUL_WAIT)       cnt_q <= cnt_q - 4'd1;
  end
`endif

  // operand latch on transfer and result capture; illegal ops bypass the ALU with a zero result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op1_q  <= '0;
      op2_q  <= '0;
      ign_q  <= 1'b0;
      ctrl_q <= OP_ADD;
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (xfer) begin
        op1_q  <= bus.in_op1;
        op2_q  <= bus.in_op2;
        ign_q  <= bus.in_ignore_op2;
        ctrl_q <= (bus.in_op == OP_ILLEGAL) ? OP_ADD : bus.in_op;
        ill_q  <= (bus.in_op == OP_ILLEGAL);
        if (bus.in_op == OP_ILLEGAL) begin
          res_q  <= '0;
          zero_q <= 1'b0;
        end
      end
      if (capture) begin
        res_q  <= bus.alu_result;
        zero_q <= bus.alu_zero;
      end
    end
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.out_valid      = out_valid_c;
  assign bus.alu_op1        = op1_q;
  assign bus.alu_op2        = op2_q;
  assign bus.alu_ignore_op2 = ign_q;
  assign bus.alu_ctrl       = ctrl_q;
  assign bus.out_result     = res_q;
  assign bus.out_zero       = zero_q;
  assign bus.out_illegal    = ill_q;

endmodule
